// File: rtl/comm_defines.sv
// Shared definitions for the frame sorter and the stream blocks it feeds.
package comm_defines;
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } sorter_state_t;

    localparam int SORT_DEPTH_DEFAULT  = 16;
    localparam int PIXEL_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/sort_insert_cell.sv
// One slot of the insertion-sorted array: decides whether it keeps its value,
// takes the new word, or takes its lower neighbour's value as the array shifts up.
module sort_insert_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = DATA_WIDTH,
    parameter bit DESCENDING = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] own_i,
    input  logic [DATA_WIDTH-1:0] lower_i,
    input  logic [DATA_WIDTH-1:0] new_i,
    input  logic                  occupied_i,
    input  logic                  insert_en_i,
    input  logic                  below_flag_i,
    output logic [DATA_WIDTH-1:0] next_o,
    output logic                  below_flag_o
);
    logic [KEY_WIDTH-1:0] own_key;
    logic [KEY_WIDTH-1:0] new_key;
    logic                 goes_before;

    assign own_key = own_i[KEY_WIDTH-1:0];
    assign new_key = new_i[KEY_WIDTH-1:0];

    // Strict compare keeps equal keys in arrival order.
    assign goes_before = DESCENDING ? (new_key > own_key) : (new_key < own_key);

    // An empty slot always accepts, so the first free slot catches "larger than all".
    assign below_flag_o = below_flag_i | ~occupied_i | goes_before;

    always_comb begin
        next_o = own_i;
        if (insert_en_i && below_flag_o) begin
            next_o = below_flag_i ? lower_i : new_i;
        end
    end
endmodule

// File: rtl/axis_frame_sorter.sv
// Collects one frame into an always-sorted register array, then replays it
// in order on the master stream.
module axis_frame_sorter
    import comm_defines::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH_DEFAULT,
    parameter int DEPTH      = SORT_DEPTH_DEFAULT,
    parameter bit DESCENDING = 1'b0,
    // Compare on the low KEY_WIDTH bits; the default is the full word.
    parameter int KEY_WIDTH  = DATA_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic [DATA_WIDTH-1:0]        s_axis_data,
    input  logic                         s_axis_last,
    output logic                         m_axis_valid,
    input  logic                         m_axis_ready,
    output logic [DATA_WIDTH-1:0]        m_axis_data,
    output logic                         m_axis_last,
    output logic [$clog2(DEPTH+1)-1:0]   frame_len,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    sorter_state_t         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         frame_len_q, frame_len_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] words_q [DEPTH];
    logic [DATA_WIDTH-1:0] words_d [DEPTH];
    logic [DEPTH-1:0]      at_or_below;
    logic                  flag_unused;
    logic                  ins_en;
    logic                  rd_is_last;

    assign ins_en      = (state_q == FILL) && s_axis_valid;
    assign flag_unused = at_or_below[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [DATA_WIDTH-1:0] lower;
        logic                  flag_in;
        if (i == 0) begin : g_first
            assign lower   = '0;
            assign flag_in = 1'b0;
        end else begin : g_rest
            assign lower   = words_q[i-1];
            assign flag_in = at_or_below[i-1];
        end
        sort_insert_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEY_WIDTH  (KEY_WIDTH),
            .DESCENDING (DESCENDING)
        ) u_cell (
            .own_i        (words_q[i]),
            .lower_i      (lower),
            .new_i        (s_axis_data),
            .occupied_i   (cnt_q > CW'(i)),
            .insert_en_i  (ins_en),
            .below_flag_i (flag_in),
            .next_o       (words_d[i]),
            .below_flag_o (at_or_below[i])
        );
    end

    assign rd_is_last = (rd_q == frame_len_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        frame_len_d = frame_len_q;
        overflow_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (s_axis_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (s_axis_last || cnt_q == CW'(DEPTH - 1)) begin
                        state_d     = DRAIN;
                        frame_len_d = cnt_q + 1'b1;
                        overflow_d  = !s_axis_last;
                    end
                end
            end
            DRAIN: begin
                if (m_axis_ready) begin
                    rd_d = rd_q + 1'b1;
                    if (rd_is_last) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        rd_d    = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            rd_q        <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
        end
    end

    // Array contents need no reset: cnt gates which slots are meaningful.
    always_ff @(posedge Clk) begin
        words_q <= words_d;
    end

    assign s_axis_ready = (state_q == FILL);
    assign m_axis_valid = (state_q == DRAIN);
    assign m_axis_data  = m_axis_valid ? words_q[rd_q[IW-1:0]] : '0;
    assign m_axis_last  = m_axis_valid && rd_is_last;
    assign frame_len    = frame_len_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_axis_frame_sorter.sv
// Directed bench for axis_frame_sorter: three configurations share one reset,
// expected words go through a scoreboard queue.
module tb_axis_frame_sorter;
    logic        clk = 1'b0;
    logic        rst;
    logic        sv [3];
    logic [31:0] sd [3];
    logic        sl [3];
    logic        mr [3];
    logic        sr [3];
    logic        mv [3];
    logic [31:0] md [3];
    logic        ml [3];
    logic        ovf [3];
    logic [4:0]  fl0;
    logic [2:0]  fl1;
    logic [4:0]  fl2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    // 0: default ascending DEPTH 16; 1: DEPTH 4 keyed on low 16 bits; 2: descending
    axis_frame_sorter u_def (
        .Clk(clk), .Reset(rst),
        .s_axis_valid(sv[0]), .s_axis_ready(sr[0]), .s_axis_data(sd[0]), .s_axis_last(sl[0]),
        .m_axis_valid(mv[0]), .m_axis_ready(mr[0]), .m_axis_data(md[0]), .m_axis_last(ml[0]),
        .frame_len(fl0), .overflow(ovf[0])
    );

    axis_frame_sorter #(.DEPTH(4), .KEY_WIDTH(16)) u_small (
        .Clk(clk), .Reset(rst),
        .s_axis_valid(sv[1]), .s_axis_ready(sr[1]), .s_axis_data(sd[1]), .s_axis_last(sl[1]),
        .m_axis_valid(mv[1]), .m_axis_ready(mr[1]), .m_axis_data(md[1]), .m_axis_last(ml[1]),
        .frame_len(fl1), .overflow(ovf[1])
    );

    axis_frame_sorter #(.DESCENDING(1'b1)) u_desc (
        .Clk(clk), .Reset(rst),
        .s_axis_valid(sv[2]), .s_axis_ready(sr[2]), .s_axis_data(sd[2]), .s_axis_last(sl[2]),
        .m_axis_valid(mv[2]), .m_axis_ready(mr[2]), .m_axis_data(md[2]), .m_axis_last(ml[2]),
        .frame_len(fl2), .overflow(ovf[2])
    );

    function automatic logic [31:0] flen(input int sel);
        case (sel)
            0:       return 32'(fl0);
            1:       return 32'(fl1);
            default: return 32'(fl2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input int sel, input logic [31:0] d, input logic last);
        sv[sel] = 1'b1;
        sd[sel] = d;
        sl[sel] = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int sel);
        sv[sel] = 1'b0;
        sd[sel] = '0;
        sl[sel] = 1'b0;
    endtask

    task automatic drain(input int sel, input int n_take, input int frame_n, input bit bp);
        int          got = 0;
        int          cyc = 0;
        logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [31:0] pd = '0;
        logic [31:0] e;
        while (got < n_take && cyc < 16 * n_take + 40) begin
            @(negedge clk);
            cyc++;
            if (pv && !pr) begin
                check("hold_valid", 32'(mv[sel]), 32'd1);
                check("hold_data", md[sel], pd);
                check("hold_last", 32'(ml[sel]), 32'(pl));
            end
            mr[sel] = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mv[sel] && mr[sel]) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("data", md[sel], e);
                    check("last", 32'(ml[sel]), 32'(got == frame_n - 1));
                end
                got++;
            end
            pv = mv[sel];
            pr = mr[sel];
            pd = md[sel];
            pl = ml[sel];
        end
        @(posedge clk);
        #1;
        mr[sel] = 1'b0;
        check("drain_count", 32'(got), 32'(n_take));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [$];
        logic [31:0] srt [$];

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(i);
            mr[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_s_ready", 32'(sr[0]), 32'd1);
        check("rst_m_valid", 32'(mv[0]), 32'd0);
        check("rst_m_last", 32'(ml[0]), 32'd0);
        check("rst_m_data", md[0], 32'd0);
        check("rst_overflow", 32'(ovf[0]), 32'd0);
        check("rst_frame_len", flen(0), 32'd0);

        // Basic ascending sort
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(9);
        send_word(0, 5, 0); send_word(0, 3, 0); send_word(0, 9, 0); send_word(0, 1, 1);
        idle(0);
        check("basic_valid_latency", 32'(mv[0]), 32'd1);
        check("basic_s_ready_low", 32'(sr[0]), 32'd0);
        check("basic_frame_len", flen(0), 32'd4);
        drain(0, 4, 4, 0);
        check("basic_turnaround_ready", 32'(sr[0]), 32'd1);
        check("basic_turnaround_valid", 32'(mv[0]), 32'd0);
        check("basic_len_held", flen(0), 32'd4);

        // Stability: equal low-16 keys keep arrival order
        exp_q.push_back(32'h2); exp_q.push_back(32'h000A_0007); exp_q.push_back(32'h000B_0007);
        send_word(1, 32'h000A_0007, 0); send_word(1, 32'h2, 0); send_word(1, 32'h000B_0007, 1);
        idle(1);
        check("stable_frame_len", flen(1), 32'd3);
        check("stable_no_overflow", 32'(ovf[1]), 32'd0);
        drain(1, 3, 3, 0);

        // Overflow at DEPTH=4, then the leftover word forms a one-word frame
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(8);
        send_word(1, 8, 0); send_word(1, 6, 0); send_word(1, 4, 0); send_word(1, 2, 0);
        idle(1);
        check("ovf_pulse", 32'(ovf[1]), 32'd1);
        check("ovf_valid", 32'(mv[1]), 32'd1);
        check("ovf_frame_len", flen(1), 32'd4);
        @(posedge clk);
        #1;
        check("ovf_pulse_end", 32'(ovf[1]), 32'd0);
        drain(1, 4, 4, 0);
        exp_q.push_back(1);
        send_word(1, 1, 1);
        idle(1);
        check("single_frame_len", flen(1), 32'd1);
        check("single_no_overflow", 32'(ovf[1]), 32'd0);
        drain(1, 1, 1, 0);

        // Backpressure over a full 16-word frame
        for (int i = 0; i < 16; i++) words.push_back($urandom);
        srt = words;
        srt.sort();
        foreach (srt[i]) exp_q.push_back(srt[i]);
        for (int i = 0; i < 16; i++) send_word(0, words[i], i == 15);
        idle(0);
        check("bp_frame_len", flen(0), 32'd16);
        check("bp_no_overflow", 32'(ovf[0]), 32'd0);
        drain(0, 16, 16, 1);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Descending with edge values
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h0);
        send_word(2, 32'h0, 0); send_word(2, 32'hFFFF_FFFF, 0); send_word(2, 32'h8000_0000, 1);
        idle(2);
        check("desc_frame_len", flen(2), 32'd3);
        drain(2, 3, 3, 0);

        // Reset part-way through a drain
        exp_q.push_back(10); exp_q.push_back(20);
        send_word(0, 30, 0); send_word(0, 10, 0); send_word(0, 40, 0); send_word(0, 20, 1);
        idle(0);
        drain(0, 2, 4, 0);
        check("mid_still_valid", 32'(mv[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(mv[0]), 32'd0);
        check("mid_rst_ready", 32'(sr[0]), 32'd1);
        check("mid_rst_frame_len", flen(0), 32'd0);
        exp_q.push_back(3); exp_q.push_back(4);
        send_word(0, 4, 0); send_word(0, 3, 1);
        idle(0);
        check("post_rst_frame_len", flen(0), 32'd2);
        drain(0, 2, 2, 0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
